// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: turns byte-addressed load/store requests into word-index
// accesses on a registered-read data memory, with read-modify-write for sub-word stores.
module load_store_unit #(
    parameter int WORD_ADDR_BITS = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_error,
    output logic [31:0] resp_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_result
);
    localparam int AW = WORD_ADDR_BITS + 2;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD   = 3'd1;
    localparam logic [2:0] WAIT = 3'd2;
    localparam logic [2:0] WR   = 3'd3;
    localparam logic [2:0] RESP = 3'd4;
    localparam logic [2:0] ERR  = 3'd5;

    // Handshake: a request transfers on a posedge with req_valid && req_ready; req_ready is
    // high only in IDLE and all req_* fields are captured on that edge.
    logic [2:0]    state;
    logic [AW-1:0] addr_q;
    logic [1:0]    size_q;
    logic          write_q;
    logic          unsigned_q;
    logic [15:0]   wdata_q;
    logic [31:0]   data_q;

    logic        req_illegal;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_ext;
    logic [31:0] merged;

    always_comb begin
        req_illegal = 1'b0;
        case (req_size)
            2'b00:   req_illegal = 1'b0;
            2'b01:   req_illegal = req_addr[0];
            2'b10:   req_illegal = |req_addr[1:0];
            default: req_illegal = 1'b1;
        endcase
        if (|req_addr[31:AW]) req_illegal = 1'b1;
    end

    // Lane extraction and merge both work on the raw memory word seen in WAIT.
    always_comb begin
        sel_byte = mem_result[{addr_q[1:0], 3'b000} +: 8];
        sel_half = mem_result[{addr_q[1], 4'b0000} +: 16];
        load_ext = mem_result;
        merged   = mem_result;
        case (size_q)
            2'b00: begin
                load_ext = unsigned_q ? {24'h0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
                merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            end
            2'b01: begin
                load_ext = unsigned_q ? {16'h0, sel_half} : {{16{sel_half[15]}}, sel_half};
                merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
            end
            default: begin
                load_ext = mem_result;
                merged   = mem_result;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            size_q     <= 2'b00;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            wdata_q    <= 16'h0;
            data_q     <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q     <= req_addr[AW-1:0];
                        size_q     <= req_size;
                        write_q    <= req_write;
                        unsigned_q <= req_unsigned;
                        wdata_q    <= req_wdata[15:0];
                        // Word stores write req_wdata straight from the data register.
                        data_q     <= req_wdata;
                        if (req_illegal)              state <= ERR;
                        else if (!req_write)          state <= RD;
                        else if (req_size == 2'b10)   state <= WR;
                        else                          state <= RD;
                    end
                end
                RD:   state <= WAIT;
                WAIT: begin
                    data_q <= write_q ? merged : load_ext;
                    state  <= write_q ? WR : RESP;
                end
                WR:      state <= RESP;
                RESP:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready      = (state == IDLE);
    assign resp_valid     = (state == RESP) || (state == ERR);
    assign resp_error     = (state == ERR);
    assign resp_rdata     = (state == RESP && !write_q) ? data_q : 32'h0;
    assign mem_read       = (state == RD);
    assign mem_write      = (state == WR);
    assign mem_address    = (state == RD || state == WR)
                            ? {{(32 - WORD_ADDR_BITS){1'b0}}, addr_q[AW-1:2]} : 32'h0;
    assign mem_write_data = (state == WR) ? data_q : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, mid-operation reset sequence and
// randomized requests checked against a byte-array reference memory.
module tb_load_store_unit;
    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_error;
    logic [31:0] resp_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_result;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [32];
    logic [7:0]  ref_mem [128];
    logic [31:0] exp_q [$];

    load_store_unit #(.WORD_ADDR_BITS(5)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_error(resp_error),
        .resp_rdata(resp_rdata), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_write_data(mem_write_data), .mem_result(mem_result)
    );

    // clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Data memory: registered read, writes ignored in reset, word i holds i after reset.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'(i);
            mem_result <= 32'h0;
        end else begin
            if (mem_write) mem[mem_address[4:0]] <= mem_write_data;
            if (mem_read) mem_result <= mem[mem_address[4:0]];
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic model_init();
        for (int w = 0; w < 32; w++)
            for (int b = 0; b < 4; b++) ref_mem[4*w+b] = (b == 0) ? 8'(w) : 8'h00;
    endtask

    // Reference: byte-array memory, alignment by modulo, extension by arithmetic.
    task automatic model_req(input logic w, input logic [1:0] sz, input logic u,
                             input logic [31:0] a, input logic [31:0] d,
                             output logic err, output logic [31:0] rdata, output int lat,
                             output int nr, output int nw,
                             output logic [31:0] waddr, output logic [31:0] wdata);
        int nb;
        longint v;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        err = (sz == 2'd3) || (a % nb != 0) || (a >= 128);
        rdata = 0; nr = 0; nw = 0; waddr = 0; wdata = 0; lat = 1;
        if (!err && !w) begin
            v = 0;
            for (int i = 0; i < nb; i++) v += longint'(ref_mem[a+i]) << (8*i);
            if (!u && nb < 4 && v >= (longint'(1) << (8*nb-1))) v -= longint'(1) << (8*nb);
            rdata = v[31:0];
            lat = 3; nr = 1;
        end else if (!err) begin
            for (int i = 0; i < nb; i++) ref_mem[a+i] = d[8*i +: 8];
            waddr = a / 4;
            for (int i = 0; i < 4; i++) wdata[8*i +: 8] = ref_mem[(a & ~32'd3) + i];
            lat = (nb == 4) ? 2 : 4;
            nr = (nb == 4) ? 0 : 1;
            nw = 1;
        end
    endtask

    // driver: present one request, then watch up to 10 cycles for the response.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic err, output logic [31:0] rdata,
                          output int nr, output int nw, output int rcyc, output int wcyc,
                          output logic [31:0] raddr, output logic [31:0] waddr,
                          output logic [31:0] wdata);
        @(negedge clock);
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = d;
        @(posedge clock);
        #1;
        req_valid = 1'b0; req_write = $urandom_range(0, 1); req_size = $urandom_range(0, 3);
        req_unsigned = $urandom_range(0, 1); req_addr = $urandom; req_wdata = $urandom;
        lat = -1; err = 1'bx; rdata = 32'hx; nr = 0; nw = 0; rcyc = -1; wcyc = -1;
        raddr = 32'hx; waddr = 32'hx; wdata = 32'hx;
        for (int c = 1; c <= 10 && lat < 0; c++) begin
            @(negedge clock);
            if (mem_read) begin nr++; rcyc = c; raddr = mem_address; end
            if (mem_write) begin nw++; wcyc = c; waddr = mem_address; wdata = mem_write_data; end
            if (resp_valid) begin lat = c; err = resp_error; rdata = resp_rdata; end
        end
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a;
        logic [31:0] d;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          nr;
        int          nw;
        logic [31:0] waddr;
        logic [31:0] wdata;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int lat, nr, nw, rcyc, wcyc, e_lat, e_nr, e_nw, bad;
        logic err, e_err;
        logic [31:0] rdata, raddr, waddr, wdata, e_rdata, e_waddr, e_wdata;
        logic w, u;
        logic [1:0] sz;
        logic [31:0] a, d;
        int r;

        vecs[0]  = '{1'b0, 2'd2, 1'b0, 32'h14, 32'h0,        1'b0, 32'h00000005, 3, 1, 0, 32'd0,  32'h0};
        vecs[1]  = '{1'b1, 2'd0, 1'b0, 32'h0C, 32'h000000AB, 1'b0, 32'h0,        4, 1, 1, 32'd3,  32'h000000AB};
        vecs[2]  = '{1'b0, 2'd0, 1'b0, 32'h0C, 32'h0,        1'b0, 32'hFFFFFFAB, 3, 1, 0, 32'd0,  32'h0};
        vecs[3]  = '{1'b0, 2'd0, 1'b1, 32'h0C, 32'h0,        1'b0, 32'h000000AB, 3, 1, 0, 32'd0,  32'h0};
        vecs[4]  = '{1'b1, 2'd1, 1'b0, 32'h1E, 32'h00008001, 1'b0, 32'h0,        4, 1, 1, 32'd7,  32'h80010007};
        vecs[5]  = '{1'b0, 2'd1, 1'b0, 32'h1E, 32'h0,        1'b0, 32'hFFFF8001, 3, 1, 0, 32'd0,  32'h0};
        vecs[6]  = '{1'b0, 2'd1, 1'b1, 32'h1E, 32'h0,        1'b0, 32'h00008001, 3, 1, 0, 32'd0,  32'h0};
        vecs[7]  = '{1'b0, 2'd2, 1'b0, 32'h1C, 32'h0,        1'b0, 32'h80010007, 3, 1, 0, 32'd0,  32'h0};
        vecs[8]  = '{1'b1, 2'd2, 1'b0, 32'h7C, 32'hDEADBEEF, 1'b0, 32'h0,        2, 0, 1, 32'd31, 32'hDEADBEEF};
        vecs[9]  = '{1'b0, 2'd2, 1'b0, 32'h7C, 32'h0,        1'b0, 32'hDEADBEEF, 3, 1, 0, 32'd0,  32'h0};
        vecs[10] = '{1'b0, 2'd2, 1'b0, 32'h02, 32'h0,        1'b1, 32'h0,        1, 0, 0, 32'd0,  32'h0};
        vecs[11] = '{1'b0, 2'd1, 1'b0, 32'h11, 32'h0,        1'b1, 32'h0,        1, 0, 0, 32'd0,  32'h0};
        vecs[12] = '{1'b0, 2'd3, 1'b0, 32'h00, 32'h0,        1'b1, 32'h0,        1, 0, 0, 32'd0,  32'h0};
        vecs[13] = '{1'b0, 2'd2, 1'b0, 32'h80, 32'h0,        1'b1, 32'h0,        1, 0, 0, 32'd0,  32'h0};

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        apply_reset();
        @(negedge clock);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_error", 32'(resp_error), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_address", mem_address, 32'h0);
        chk("rst_mem_write_data", mem_write_data, 32'h0);

        for (int i = 0; i < 14; i++) begin
            do_req(vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].a, vecs[i].d,
                   lat, err, rdata, nr, nw, rcyc, wcyc, raddr, waddr, wdata);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d_error", i), 32'(err), 32'(vecs[i].err));
            chk($sformatf("v%0d_rdata", i), rdata, vecs[i].rdata);
            chk($sformatf("v%0d_reads", i), 32'(nr), 32'(vecs[i].nr));
            chk($sformatf("v%0d_writes", i), 32'(nw), 32'(vecs[i].nw));
            if (vecs[i].nr == 1) begin
                chk($sformatf("v%0d_read_cycle", i), 32'(rcyc), 32'd1);
                chk($sformatf("v%0d_read_index", i), raddr, vecs[i].a >> 2);
            end
            if (vecs[i].nw == 1) begin
                chk($sformatf("v%0d_write_cycle", i), 32'(wcyc), 32'(vecs[i].lat - 1));
                chk($sformatf("v%0d_write_index", i), waddr, vecs[i].waddr);
                chk($sformatf("v%0d_write_data", i), wdata, vecs[i].wdata);
            end
        end

        // Reset lands while the byte store at 0x08 is in WAIT; it must vanish silently.
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h08; req_wdata = 32'h00000055;
        @(posedge clock);
        #1 req_valid = 1'b0;
        bad = 0;
        @(negedge clock);
        if (resp_valid || mem_write) bad++;
        @(negedge clock);
        if (resp_valid || mem_write) bad++;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (resp_valid || mem_write || mem_read) bad++;
        end
        chk("midrst_activity", 32'(bad), 32'd0);
        do_req(1'b0, 2'd2, 1'b0, 32'h08, 32'h0, lat, err, rdata, nr, nw, rcyc, wcyc,
               raddr, waddr, wdata);
        chk("midrst_lw_latency", 32'(lat), 32'd3);
        chk("midrst_lw_rdata", rdata, 32'h00000002);
        chk("midrst_lw_error", 32'(err), 32'd0);

        // Randomized requests against the reference model.
        apply_reset();
        model_init();
        for (int n = 0; n < 200; n++) begin
            w = 1'($urandom_range(0, 1));
            u = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 15);
            sz = (r == 15) ? 2'd3 : 2'(r % 3);
            a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 127));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            d = $urandom;
            model_req(w, sz, u, a, d, e_err, e_rdata, e_lat, e_nr, e_nw, e_waddr, e_wdata);
            exp_q.push_back(e_rdata);
            do_req(w, sz, u, a, d, lat, err, rdata, nr, nw, rcyc, wcyc, raddr, waddr, wdata);
            chk($sformatf("rnd%0d_latency", n), 32'(lat), 32'(e_lat));
            chk($sformatf("rnd%0d_error", n), 32'(err), 32'(e_err));
            chk($sformatf("rnd%0d_rdata", n), rdata, exp_q.pop_front());
            chk($sformatf("rnd%0d_reads", n), 32'(nr), 32'(e_nr));
            chk($sformatf("rnd%0d_writes", n), 32'(nw), 32'(e_nw));
            if (e_nr == 1) chk($sformatf("rnd%0d_read_index", n), raddr, a >> 2);
            if (e_nw == 1) begin
                chk($sformatf("rnd%0d_write_cycle", n), 32'(wcyc), 32'(e_lat - 1));
                chk($sformatf("rnd%0d_write_index", n), waddr, e_waddr);
                chk($sformatf("rnd%0d_write_data", n), wdata, e_wdata);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
